// File: rtl/mem_read_streamer.sv
// mem_read_streamer: walks len consecutive addresses of a 1-cycle synchronous read port and
// streams the returned words on valid/ready. Optional macro RDSTREAM_NOWRAP_EN rejects wrapping starts.
module mem_read_streamer #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] addr_rd,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(1'b0);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1'b1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = (ADDR_W)'(1'b1);

  logic [1:0]        state_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   iss_cnt_r;
  logic [ADDR_W:0]   acc_cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        occ_r;
  logic              inflight_r;
  logic [DATA_W-1:0] head_r;
  logic [DATA_W-1:0] tail_r;
  logic [ADDR_W:0]   len_m1_s;
  logic [2:0]        live_s;
  logic              push_s;
  logic              pop_s;
  logic              reject_s;

  assign len_m1_s = len_r - CNT_ONE;
  assign push_s   = inflight_r;
  assign pop_s    = out_valid & out_ready;

  // Words buffered or returning this cycle, crediting the word leaving downstream right now.
  // The pop credit is what lets a 2-entry buffer sustain one word per cycle.
  assign live_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};

  assign rd_en     = (state_r == READ) && (iss_cnt_r != len_r) && (live_s < 3'd2);
  assign addr_rd   = addr_r;
  assign busy      = (state_r == READ) || (state_r == DRAIN);
  assign done      = (state_r == FIN);
  assign out_valid = (occ_r != 2'd0);
  assign out_data  = head_r;
  assign out_last  = out_valid && (acc_cnt_r == len_m1_s);

`ifdef RDSTREAM_NOWRAP_EN
  logic err_r;

  assign reject_s = ({2'b00, base_addr} + {1'b0, len}) > {1'b0, DEPTH_L};

  // Rejected-start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (state_r == IDLE) && start && reject_s;
    end
  end

  assign err = err_r;
`else
  assign reject_s = 1'b0;
  assign err      = 1'b0;
`endif

  // Transfer sequencing, issue address and issued/accepted counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      len_r     <= CNT_ZERO;
      iss_cnt_r <= CNT_ZERO;
      acc_cnt_r <= CNT_ZERO;
      addr_r    <= {ADDR_W{1'b0}};
    end else begin
      if (pop_s) begin
        acc_cnt_r <= acc_cnt_r + CNT_ONE;
      end
      case (state_r)
        IDLE: begin
          if (start && !reject_s) begin
            if (len == CNT_ZERO) begin
              state_r <= FIN;
            end else begin
              state_r   <= READ;
              len_r     <= (len > DEPTH_L) ? DEPTH_L : len;
              addr_r    <= base_addr;
              iss_cnt_r <= CNT_ZERO;
              acc_cnt_r <= CNT_ZERO;
            end
          end
        end
        READ: begin
          if (rd_en) begin
            addr_r    <= addr_r + ADDR_ONE;
            iss_cnt_r <= iss_cnt_r + CNT_ONE;
            if (iss_cnt_r == len_m1_s) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop_s && (acc_cnt_r == len_m1_s)) begin
            state_r <= FIN;
          end
        end
        FIN: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Two-entry output buffer; head_r is always the word presented downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      head_r     <= {DATA_W{1'b0}};
      tail_r     <= {DATA_W{1'b0}};
    end else begin
      inflight_r <= rd_en;
      case (occ_r)
        2'd0: begin
          if (push_s) begin
            head_r <= rd_data;
            occ_r  <= 2'd1;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            head_r <= rd_data;
          end else if (push_s) begin
            tail_r <= rd_data;
            occ_r  <= 2'd2;
          end else if (pop_s) begin
            occ_r <= 2'd0;
          end
        end
        2'd2: begin
          if (pop_s) begin
            head_r <= tail_r;
            if (push_s) begin
              tail_r <= rd_data;
            end else begin
              occ_r <= 2'd1;
            end
          end
        end
        default: begin
          occ_r <= 2'd0;
        end
      endcase
    end
  end

endmodule
